// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, funct3 codes, cause codes and strobe helper for the load/store sequencer
package lsu_pkg;
   typedef enum logic [2:0] {IDLE, REQ, RSP, WB, ERR} lsu_state_e;
   localparam logic [2:0] LSU_F3_B  = 3'b000;
   localparam logic [2:0] LSU_F3_H  = 3'b001;
   localparam logic [2:0] LSU_F3_W  = 3'b010;
   localparam logic [2:0] LSU_F3_BU = 3'b100;
   localparam logic [2:0] LSU_F3_HU = 3'b101;
   localparam logic [1:0] LSU_CAUSE_LD_MIS = 2'd0;
   localparam logic [1:0] LSU_CAUSE_ST_MIS = 2'd1;
   localparam logic [1:0] LSU_CAUSE_ILL    = 2'd2;
   localparam logic [1:0] LSU_CAUSE_FAULT  = 2'd3;
   // funct3[1:0] encodes access size: 00 byte, 01 halfword, 10 word
   function automatic logic [3:0] lsu_strb(input logic [2:0] f3, input logic [1:0] off);
      return f3[1] ? 4'b1111 : f3[0] ? 4'b0011 << off : 4'b0001 << off;
   endfunction
endpackage

// File: rtl/lsu_ld_ext.sv
// lsu_ld_ext: selects the addressed lane of a read word and sign/zero-extends it
module lsu_ld_ext
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);
   logic [31:0] lane;
   // shift the addressed byte lane down to bit 0, then extend by access type
   always_comb begin
      lane = rdata >> {addr, 3'b000};
      data = funct3 == LSU_F3_B  ? {{24{lane[7]}}, lane[7:0]} :
             funct3 == LSU_F3_H  ? {{16{lane[15]}}, lane[15:0]} :
             funct3 == LSU_F3_BU ? {24'd0, lane[7:0]} :
             funct3 == LSU_F3_HU ? {16'd0, lane[15:0]} : lane;
   end
endmodule

// File: rtl/exu_lsu_ctrl.sv
// exu_lsu_ctrl: sequences one EXU memory op at a time onto the ldst bus with checks and load writeback
module exu_lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            op_vld,
   output logic            op_rdy,
   input  logic            op_is_ld,
   input  logic [2:0]      op_funct3,
   input  logic [XLEN-1:0] op_addr,
   input  logic [XLEN-1:0] op_wdata,
   input  logic [4:0]      op_rd,
   output logic            req_vld,
   input  logic            req_rdy,
   output logic [XLEN-1:0] req_addr,
   output logic            req_wr,
   output logic [3:0]      req_wstrb,
   output logic [XLEN-1:0] req_wdata,
   input  logic            rsp_vld,
   output logic            rsp_rdy,
   input  logic [XLEN-1:0] rsp_rdata,
   input  logic            rsp_err,
   output logic            wb_vld,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            done,
   output logic            err_vld,
   output logic [1:0]      err_cause
);
   lsu_state_e  state;
   logic        is_ld_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [4:0]  rd_q;
   logic [31:0] ext;
   logic        legal;
   logic        mis;

   lsu_ld_ext u_ext (
      .rdata (rsp_rdata),
      .addr  (addr_q[1:0]),
      .funct3(f3_q),
      .data  (ext)
   );

   // legality and alignment of the op offered by the EXU; illegal funct3 wins over misalignment
   always_comb begin
      legal = op_is_ld ? op_funct3 inside {LSU_F3_B, LSU_F3_H, LSU_F3_W, LSU_F3_BU, LSU_F3_HU}
                       : op_funct3 inside {LSU_F3_B, LSU_F3_H, LSU_F3_W};
      mis   = (op_funct3[1:0] == 2'b01 && op_addr[0]) || (op_funct3[1:0] == 2'b10 && op_addr[1:0] != 2'b00);
   end

   // sequencer: accept, request, wait for response, then writeback or exception
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         is_ld_q   <= 1'b0;
         f3_q      <= 3'd0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_q      <= '0;
         wb_data   <= '0;
         err_cause <= 2'd0;
      end else begin
         case (state)
            IDLE: if (op_vld) begin
               is_ld_q <= op_is_ld;
               f3_q    <= op_funct3;
               addr_q  <= op_addr;
               wdata_q <= op_wdata;
               rd_q    <= op_rd;
               if (!legal) begin
                  state     <= ERR;
                  err_cause <= LSU_CAUSE_ILL;
               end else if (mis) begin
                  state     <= ERR;
                  err_cause <= op_is_ld ? LSU_CAUSE_LD_MIS : LSU_CAUSE_ST_MIS;
               end else begin
                  state <= REQ;
               end
            end
            REQ: if (req_rdy) state <= RSP;
            RSP: if (rsp_vld) begin
               if (rsp_err) begin
                  state     <= ERR;
                  err_cause <= LSU_CAUSE_FAULT;
               end else if (is_ld_q) begin
                  state   <= WB;
                  wb_data <= ext;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // request fields are zero outside REQ so reset and idle present a clean bus
   always_comb begin
      op_rdy    = state == IDLE;
      req_vld   = state == REQ;
      req_addr  = req_vld ? {addr_q[31:2], 2'b00} : '0;
      req_wr    = req_vld & ~is_ld_q;
      req_wstrb = req_vld ? lsu_strb(f3_q, addr_q[1:0]) : 4'd0;
      req_wdata = !req_vld ? '0 : f3_q[1] ? wdata_q : f3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
      rsp_rdy   = state == RSP;
      wb_vld    = state == WB;
      wb_rd     = rd_q;
      err_vld   = state == ERR;
      done      = wb_vld | err_vld | (rsp_rdy & rsp_vld & ~rsp_err & ~is_ld_q);
   end
endmodule

// File: tb/tb_exu_lsu_ctrl.sv
// tb_exu_lsu_ctrl: directed scoreboard bench for the load/store sequencer
module tb_exu_lsu_ctrl;
   import lsu_pkg::*;

   typedef struct packed {
      logic [31:0] addr;
      logic        wr;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } req_t;

   typedef struct packed {
      logic        wb;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        err;
      logic [1:0]  cause;
   } ret_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        op_vld = 1'b0, op_rdy, op_is_ld = 1'b0;
   logic [2:0]  op_funct3 = 3'd0;
   logic [31:0] op_addr = '0, op_wdata = '0;
   logic [4:0]  op_rd = '0;
   logic        req_vld, req_rdy = 1'b0, req_wr;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_vld = 1'b0, rsp_rdy, rsp_err = 1'b0;
   logic [31:0] rsp_rdata = '0;
   logic        wb_vld, done, err_vld;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [1:0]  err_cause;
   logic [31:0] x_rdata = '0, x_data;
   logic [1:0]  x_off = '0;
   logic [2:0]  x_f3 = '0;

   int   vectors = 0;
   int   miscompares = 0;
   int   hs_cnt = 0;
   req_t req_q[$];
   ret_t ret_q[$];

   always #5 clk = ~clk;

   exu_lsu_ctrl #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .op_vld(op_vld), .op_rdy(op_rdy), .op_is_ld(op_is_ld), .op_funct3(op_funct3),
      .op_addr(op_addr), .op_wdata(op_wdata), .op_rd(op_rd),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr), .req_wr(req_wr),
      .req_wstrb(req_wstrb), .req_wdata(req_wdata),
      .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .wb_vld(wb_vld), .wb_rd(wb_rd), .wb_data(wb_data),
      .done(done), .err_vld(err_vld), .err_cause(err_cause)
   );

   lsu_ld_ext u_ext (.rdata(x_rdata), .addr(x_off), .funct3(x_f3), .data(x_data));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic req_t mk_req(input logic [31:0] a, input logic wr, input logic [3:0] s, input logic [31:0] d);
      req_t r;
      r.addr = a; r.wr = wr; r.strb = s; r.wdata = d;
      return r;
   endfunction

   function automatic ret_t mk_ret(input logic wb, input logic [4:0] rd, input logic [31:0] d, input logic err, input logic [1:0] c);
      ret_t r;
      r.wb = wb; r.rd = rd; r.data = d; r.err = err; r.cause = c;
      return r;
   endfunction

   // request monitor: every bus handshake must match the next queued request
   always @(negedge clk) begin : mon_req
      req_t e;
      if (rst_n && req_vld && req_rdy) begin
         hs_cnt++;
         if (req_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
         else begin
            e = req_q.pop_front();
            chk("req_addr", req_addr, e.addr);
            chk("req_wr", {31'd0, req_wr}, {31'd0, e.wr});
            chk("req_wstrb", {28'd0, req_wstrb}, {28'd0, e.strb});
            chk("req_wdata", req_wdata, e.wdata);
         end
      end
   end

   // retirement monitor: every done/wb/err pulse must match the next queued retirement
   always @(negedge clk) begin : mon_ret
      ret_t e;
      if (rst_n && (done || wb_vld || err_vld)) begin
         if (ret_q.size() == 0) chk("unexpected_retire", 32'd1, 32'd0);
         else begin
            e = ret_q.pop_front();
            chk("done", {31'd0, done}, 32'd1);
            chk("wb_vld", {31'd0, wb_vld}, {31'd0, e.wb});
            chk("err_vld", {31'd0, err_vld}, {31'd0, e.err});
            if (e.wb) begin
               chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
               chk("wb_data", wb_data, e.data);
            end
            if (e.err) chk("err_cause", {30'd0, err_cause}, {30'd0, e.cause});
         end
      end
   end

   task automatic check_reset(input string tag);
      chk({tag, "_op_rdy"}, {31'd0, op_rdy}, 32'd1);
      chk({tag, "_req_vld"}, {31'd0, req_vld}, 32'd0);
      chk({tag, "_req_addr"}, req_addr, 32'd0);
      chk({tag, "_req_wr"}, {31'd0, req_wr}, 32'd0);
      chk({tag, "_req_wstrb"}, {28'd0, req_wstrb}, 32'd0);
      chk({tag, "_req_wdata"}, req_wdata, 32'd0);
      chk({tag, "_rsp_rdy"}, {31'd0, rsp_rdy}, 32'd0);
      chk({tag, "_wb_vld"}, {31'd0, wb_vld}, 32'd0);
      chk({tag, "_wb_rd"}, {27'd0, wb_rd}, 32'd0);
      chk({tag, "_wb_data"}, wb_data, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_err_vld"}, {31'd0, err_vld}, 32'd0);
      chk({tag, "_err_cause"}, {30'd0, err_cause}, 32'd0);
   endtask

   task automatic ext_chk(input logic [31:0] rd, input logic [1:0] off, input logic [2:0] f3, input logic [31:0] exp);
      x_rdata = rd; x_off = off; x_f3 = f3;
      #1;
      chk("ld_ext", x_data, exp);
   endtask

   // issues one op, holds the bus responder for it, checks latency, stall stability and handshake count
   task automatic run_op(input logic ld, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] rdata, input logic rerr, input int rwait,
                         input logic has_req, input req_t er, input ret_t et, input int lat);
      int n;
      int h0;
      h0 = hs_cnt;
      chk("op_rdy_before", {31'd0, op_rdy}, 32'd1);
      if (has_req) req_q.push_back(er);
      ret_q.push_back(et);
      op_vld = 1'b1; op_is_ld = ld; op_funct3 = f3; op_addr = a; op_wdata = wd; op_rd = rd;
      rsp_vld = 1'b1; rsp_rdata = rdata; rsp_err = rerr; req_rdy = 1'b0;
      @(posedge clk); #1;
      op_vld = 1'b0;
      n = 1;
      chk("req_vld_after_accept", {31'd0, req_vld}, {31'd0, has_req});
      req_rdy = n > rwait;
      while (!done && n < 40) begin
         if (req_vld && !req_rdy) begin
            chk("stall_addr", req_addr, er.addr);
            chk("stall_strb", {28'd0, req_wstrb}, {28'd0, er.strb});
            chk("stall_wdata", req_wdata, er.wdata);
            chk("stall_op_rdy", {31'd0, op_rdy}, 32'd0);
         end
         @(posedge clk); #1;
         n++;
         req_rdy = n > rwait;
      end
      chk("latency", n, lat);
      @(posedge clk); #1;
      chk("op_rdy_after", {31'd0, op_rdy}, 32'd1);
      chk("req_handshakes", hs_cnt - h0, {31'd0, has_req});
      rsp_vld = 1'b0; rsp_err = 1'b0; req_rdy = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      ext_chk(32'h80010000, 2'd2, LSU_F3_H,  32'hFFFF8001);
      ext_chk(32'h80010000, 2'd2, LSU_F3_HU, 32'h00008001);
      ext_chk(32'h00007F00, 2'd1, LSU_F3_B,  32'h0000007F);
      ext_chk(32'h00FF0000, 2'd2, LSU_F3_B,  32'hFFFFFFFF);
      ext_chk(32'h00FF0000, 2'd2, LSU_F3_BU, 32'h000000FF);
      ext_chk(32'h12345678, 2'd0, LSU_F3_W,  32'h12345678);

      #5;
      check_reset("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      rsp_vld = 1'b1;
      @(posedge clk); #1;
      chk("idle_rsp_rdy", {31'd0, rsp_rdy}, 32'd0);
      chk("idle_rsp_done", {31'd0, done}, 32'd0);
      rsp_vld = 1'b0;
      @(posedge clk); #1;

      run_op(1, LSU_F3_W,  32'h1000, 32'h0, 5'd5, 32'hDEADBEEF, 0, 0, 1,
             mk_req(32'h1000, 0, 4'b1111, 32'h0), mk_ret(1, 5'd5, 32'hDEADBEEF, 0, 0), 3);
      run_op(1, LSU_F3_B,  32'h2003, 32'h0, 5'd7, 32'h80000000, 0, 0, 1,
             mk_req(32'h2000, 0, 4'b1000, 32'h0), mk_ret(1, 5'd7, 32'hFFFFFF80, 0, 0), 3);
      run_op(1, LSU_F3_BU, 32'h2003, 32'h0, 5'd7, 32'h80000000, 0, 0, 1,
             mk_req(32'h2000, 0, 4'b1000, 32'h0), mk_ret(1, 5'd7, 32'h00000080, 0, 0), 3);
      run_op(0, LSU_F3_H,  32'h3002, 32'h1234ABCD, 5'd0, 32'h0, 0, 0, 1,
             mk_req(32'h3000, 1, 4'b1100, 32'hABCDABCD), mk_ret(0, 5'd0, 32'h0, 0, 0), 2);
      run_op(1, LSU_F3_W,  32'h4001, 32'h0, 5'd1, 32'h0, 0, 0, 0,
             mk_req(32'h0, 0, 4'b0, 32'h0), mk_ret(0, 5'd0, 32'h0, 1, 2'd0), 1);
      run_op(0, 3'b011,    32'h5000, 32'h0, 5'd0, 32'h0, 0, 0, 0,
             mk_req(32'h0, 0, 4'b0, 32'h0), mk_ret(0, 5'd0, 32'h0, 1, 2'd2), 1);
      run_op(0, LSU_F3_W,  32'h6000, 32'hCAFEF00D, 5'd0, 32'h0, 0, 5, 1,
             mk_req(32'h6000, 1, 4'b1111, 32'hCAFEF00D), mk_ret(0, 5'd0, 32'h0, 0, 0), 7);
      run_op(1, LSU_F3_H,  32'h7001, 32'h0, 5'd2, 32'h0, 0, 0, 0,
             mk_req(32'h0, 0, 4'b0, 32'h0), mk_ret(0, 5'd0, 32'h0, 1, 2'd0), 1);
      run_op(0, LSU_F3_B,  32'h7001, 32'h000000A5, 5'd0, 32'h0, 0, 0, 1,
             mk_req(32'h7000, 1, 4'b0010, 32'hA5A5A5A5), mk_ret(0, 5'd0, 32'h0, 0, 0), 2);
      run_op(0, LSU_F3_H,  32'h7003, 32'h0, 5'd0, 32'h0, 0, 0, 0,
             mk_req(32'h0, 0, 4'b0, 32'h0), mk_ret(0, 5'd0, 32'h0, 1, 2'd1), 1);
      run_op(1, 3'b011,    32'h7001, 32'h0, 5'd2, 32'h0, 0, 0, 0,
             mk_req(32'h0, 0, 4'b0, 32'h0), mk_ret(0, 5'd0, 32'h0, 1, 2'd2), 1);
      run_op(0, LSU_F3_BU, 32'h7000, 32'h0, 5'd0, 32'h0, 0, 0, 0,
             mk_req(32'h0, 0, 4'b0, 32'h0), mk_ret(0, 5'd0, 32'h0, 1, 2'd2), 1);
      run_op(1, LSU_F3_HU, 32'h8002, 32'h0, 5'd0, 32'hF00D1234, 0, 0, 1,
             mk_req(32'h8000, 0, 4'b1100, 32'h0), mk_ret(1, 5'd0, 32'h0000F00D, 0, 0), 3);
      run_op(1, LSU_F3_W,  32'h9000, 32'h0, 5'd9, 32'h11111111, 1, 0, 1,
             mk_req(32'h9000, 0, 4'b1111, 32'h0), mk_ret(0, 5'd0, 32'h0, 1, 2'd3), 3);

      req_q.push_back(mk_req(32'hA000, 0, 4'b1111, 32'h0));
      op_vld = 1'b1; op_is_ld = 1'b1; op_funct3 = LSU_F3_W; op_addr = 32'hA000; op_rd = 5'd3;
      req_rdy = 1'b1; rsp_vld = 1'b0;
      @(posedge clk); #1;
      op_vld = 1'b0;
      @(posedge clk); #1;
      req_rdy = 1'b0;
      chk("rsp_rdy_in_rsp", {31'd0, rsp_rdy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_reset("async_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(0, LSU_F3_B,  32'hB000, 32'h0000005A, 5'd0, 32'h0, 0, 0, 1,
             mk_req(32'hB000, 1, 4'b0001, 32'h5A5A5A5A), mk_ret(0, 5'd0, 32'h0, 0, 0), 2);

      repeat (3) @(posedge clk);
      chk("req_queue_drained", req_q.size(), 32'd0);
      chk("ret_queue_drained", ret_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/exu_lsu_ctrl.md
# exu_lsu_ctrl

Load/store sequencer that sits between the execute unit and its `ldst_if` master port. It accepts one decoded memory operation at a time from the EXU and checks alignment and funct3 legality. Legal operations become a single word-aligned bus request with byte strobes. Load responses are realigned and sign- or zero-extended before a register writeback pulse. The EXU stalls on `op_rdy` while an operation is in flight.

## Interface
Parameters:
- `XLEN`, 32: data and address width; only 32 is supported.

Ports:
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op_vld`  in  1  EXU presents a memory operation.
- `op_rdy`  out  1  controller can accept an operation.
- `op_is_ld`  in  1  1 = load, 0 = store.
- `op_funct3`  in  3  RV32I LOAD/STORE funct3.
- `op_addr`  in  32  effective byte address.
- `op_wdata`  in  32  store data, in the low bits.
- `op_rd`  in  5  load destination register.
- `req_vld`  out  1  bus request valid.
- `req_rdy`  in  1  bus accepts the request.
- `req_addr`  out  32  word address; bits [1:0] are always 0.
- `req_wr`  out  1  1 = write.
- `req_wstrb`  out  4  byte strobes, also driven on reads.
- `req_wdata`  out  32  lane-shifted store data.
- `rsp_vld`  in  1  bus response valid.
- `rsp_rdy`  out  1  controller accepts the response.
- `rsp_rdata`  in  32  read word.
- `rsp_err`  in  1  access fault.
- `wb_vld`  out  1  one-cycle load writeback pulse.
- `wb_rd`  out  5  writeback register.
- `wb_data`  out  32  extended load data.
- `done`  out  1  one-cycle pulse when any operation retires.
- `err_vld`  out  1  one-cycle exception pulse, coincident with `done`.
- `err_cause`  out  2  0 = load misaligned, 1 = store misaligned, 2 = illegal funct3, 3 = access fault.

## Operation
- FSM states: IDLE, REQ, RSP, WB, ERR. Reset forces IDLE.
- `op_rdy` = 1 only in IDLE. An op is accepted on `op_vld & op_rdy`; all op fields are registered.
- Legal funct3:
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
  - Any other code → ERR with cause 2.
- Misalignment:
  - Halfword with `addr[0]` = 1 → ERR.
  - Word with `addr[1:0]` ≠ 0 → ERR.
  - Cause is 0 for a load, 1 for a store.
  - Illegal funct3 takes priority over misalignment.
- ERR state issues no bus request. It pulses `err_vld`/`done` for one cycle, then returns to IDLE.
- REQ: `req_vld` = 1, and every `req_*` field is held stable until `req_rdy`.
  - Strobes: byte op = 1 << `addr[1:0]`; halfword op = 0011 << `addr[1:0]`; word op = 1111.
  - `req_wdata`: byte data replicated ×4, halfword data replicated ×2, word data unchanged.
- After the request handshake → RSP with `rsp_rdy` = 1.
  - Store response: retire by pulsing `done` in the handshake cycle, then go to IDLE.
  - Load response: latch the extended data and go to WB.
- WB pulses `wb_vld`/`done` for one cycle with the registered `wb_rd`/`wb_data`, then goes to IDLE.
  - `wb_vld` pulses even when `rd` = 0; the register file drops that write.
- Extension: select the lane with `addr[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend.
- `rsp_err` = 1 on the response handshake aborts the op:
  - No `wb_vld`.
  - `err_vld` = 1 with cause 3, together with `done`, in the following cycle via ERR.
- `rsp_vld` arriving outside RSP is ignored, since `rsp_rdy` = 0 there.

## Timing
- Reset values: `op_rdy` = 1; every other output is 0, including `req_addr`, `wb_data` and `err_cause`.
- Load latency with zero bus wait: accept at T, `req_vld` at T+1, `rsp_rdy` at T+2, `wb_vld` at T+3, `op_rdy` at T+4.
- Store latency: accept at T, request at T+1, `done` at T+2, `op_rdy` at T+3.
- Error latency: accept at T, `err_vld` at T+1, `op_rdy` at T+2.
- Bus back-pressure extends REQ or RSP indefinitely, with no timeout.
- `rsp_vld` in the same cycle as the request handshake is not accepted; the response is taken in RSP at the earliest one cycle later.
- An asynchronous reset mid-operation drops the op silently: no `done`, and `req_vld` deasserts immediately.

## Structure
- Package `lsu_pkg` holds:
  - the state enum;
  - funct3 localparams (`LSU_F3_B`/`H`/`W`/`BU`/`HU`);
  - the cause-code constants;
  - the strobe-generation function.
- Sub-module `lsu_ld_ext` is combinational. It takes `rdata`, `addr[1:0]` and `funct3` and produces the extended data. Verification covers it standalone.
- Everything else lives in a single always_ff FSM plus combinational request formatting.

## Test plan
- LW at 0x1000, bus returns 0xDEADBEEF with `req_rdy` = `rsp_vld` = 1 → `req_addr` 0x1000, `wstrb` 1111, `wb_data` 0xDEADBEEF at T+3.
- LB at 0x2003 with rdata 0x80000000 → `wstrb` 1000, `wb_data` 0xFFFFFF80. The same op as LBU → 0x00000080.
- SH at 0x3002 with `wdata` 0x1234ABCD → `req_wdata` 0xABCDABCD, `wstrb` 1100, `req_wr` 1, `done` and no `wb_vld`.
- LW at 0x4001 → no `req_vld`, `err_vld` with cause 0 at T+1. SW with funct3 011 → cause 2.
- `req_rdy` held 0 for 5 cycles, then 1 → `req_*` stable throughout, `op_rdy` 0 throughout, and only one request handshake.
- Load with `rsp_err` = 1 → cause 3, no `wb_vld`. Reset asserted while in RSP → all outputs return to reset values asynchronously.
